// File: rtl/sysbus_pkg.sv
// System bus encodings shared by the line transfer engine: request tags and
// the transfer FSM state type.
package sysbus_pkg;

    localparam logic       SYSBUS_READ     = 1'b0;
    localparam logic       SYSBUS_WRITE    = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY   = 4'b0001;
    localparam int         SYSBUS_TAG_BITS = 13;

    typedef enum logic [2:0] {
        XFER_IDLE  = 3'd0,
        XFER_ARB   = 3'd1,
        XFER_ADDR  = 3'd2,
        XFER_WDATA = 3'd3,
        XFER_RWAIT = 3'd4,
        XFER_DONE  = 3'd5
    } xfer_state_t;

    // Tag layout: op in bit 12, device id in bits 11:8, low byte reserved.
    function automatic logic [SYSBUS_TAG_BITS-1:0] sysbus_tag(input logic op, input logic [3:0] dev);
        return {op, dev, 8'h00};
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Cache-line holding register with a beat-indexed write port, a full-line
// load port and a beat-indexed read mux.
module line_beat_buffer #(
    parameter int LINE_WIDTH = 512,
    parameter int BEAT_WIDTH = 64,
    parameter int BEAT_IDX_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [LINE_WIDTH-1:0] i_line,
    input  logic                  i_wr_en,
    input  logic [BEAT_IDX_W-1:0] i_beat,
    input  logic [BEAT_WIDTH-1:0] i_beat_data,
    output logic [LINE_WIDTH-1:0] o_line,
    output logic [BEAT_WIDTH-1:0] o_beat_data
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;

    logic [LINE_WIDTH-1:0] r_line;
    logic [BEAT_WIDTH-1:0] w_beat;

    // Line storage: a full load wins over a single-beat write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_wr_en) begin
            for (int b = 0; b < BEATS; b++) begin
                if (i_beat == BEAT_IDX_W'(b)) begin
                    r_line[b*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
                end
            end
        end
    end

    // Beat read mux; an index past the last beat reads as zero.
    always_comb begin
        w_beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            w_beat = w_beat | ((i_beat == BEAT_IDX_W'(b)) ? r_line[b*BEAT_WIDTH +: BEAT_WIDTH] : '0);
        end
    end

    assign o_line      = r_line;
    assign o_beat_data = w_beat;

endmodule

// File: rtl/line_bus_xfer.sv
// Cache-line transfer engine: arbitrates for the system bus, then issues an
// address beat followed by either the writeback data beats or a tagged fill.
module line_bus_xfer
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_WIDTH     = 512,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [LINE_WIDTH-1:0]     wdata,
    output logic [LINE_WIDTH-1:0]     rdata,
    output logic                      ready,
    output logic                      abtr_reqcyc,
    input  logic                      abtr_grant,
    output logic                      bus_busy,
    output logic                      main_bus_reqcyc,
    input  logic                      main_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
    input  logic                      main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
    output logic                      main_bus_respack
);

    localparam int BEATS  = LINE_WIDTH / BUS_DATA_WIDTH;
    localparam int OFFS   = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam logic [BEAT_W-1:0]        BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0]    ALIGN_MASK = ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_RD     = BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_READ, SYSBUS_MEMORY));
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR     = BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_WRITE, SYSBUS_MEMORY));

    xfer_state_t               r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_write;
    logic                      w_start;
    logic                      w_respack;
    logic [BUS_DATA_WIDTH-1:0] w_wbeat;

    assign w_start   = enable && ((r_state == XFER_IDLE) || (r_state == XFER_DONE));
    assign w_respack = (r_state == XFER_RWAIT) && main_bus_respcyc && (main_bus_resptag == TAG_RD);

    line_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BUS_DATA_WIDTH),
        .BEAT_IDX_W (BEAT_W)
    ) u_wline (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_load      (w_start),
        .i_line      (wdata),
        .i_wr_en     (1'b0),
        .i_beat      (r_beat),
        .i_beat_data ({BUS_DATA_WIDTH{1'b0}}),
        .o_line      (),
        .o_beat_data (w_wbeat)
    );

    line_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BUS_DATA_WIDTH),
        .BEAT_IDX_W (BEAT_W)
    ) u_rline (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_load      (1'b0),
        .i_line      ({LINE_WIDTH{1'b0}}),
        .i_wr_en     (w_respack),
        .i_beat      (r_beat),
        .i_beat_data (main_bus_resp),
        .o_line      (rdata),
        .o_beat_data ()
    );

    // Transfer sequencing; the beat counter is one bit wider than needed so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= XFER_IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                XFER_IDLE, XFER_DONE: begin
                    if (enable) begin
                        r_addr  <= addr & ALIGN_MASK;
                        r_write <= write;
                        r_state <= XFER_ARB;
                    end
                end
                XFER_ARB: begin
                    if (abtr_grant) begin
                        r_beat  <= '0;
                        r_state <= XFER_ADDR;
                    end
                end
                XFER_ADDR: begin
                    if (main_bus_reqack) begin
                        r_beat  <= '0;
                        r_state <= r_write ? XFER_WDATA : XFER_RWAIT;
                    end
                end
                XFER_WDATA: begin
                    if (main_bus_reqack) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == BEAT_LAST) begin
                            r_state <= XFER_DONE;
                        end
                    end
                end
                XFER_RWAIT: begin
                    if (w_respack) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == BEAT_LAST) begin
                            r_state <= XFER_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= XFER_IDLE;
                end
            endcase
        end
    end

    // Moore output decode of the state and beat registers.
    always_comb begin
        ready           = 1'b0;
        abtr_reqcyc     = 1'b0;
        bus_busy        = 1'b0;
        main_bus_reqcyc = 1'b0;
        main_bus_req    = '0;
        main_bus_reqtag = '0;
        case (r_state)
            XFER_ARB: begin
                abtr_reqcyc = 1'b1;
            end
            XFER_ADDR: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = BUS_DATA_WIDTH'(r_addr);
                main_bus_reqtag = r_write ? TAG_WR : TAG_RD;
            end
            XFER_WDATA: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = w_wbeat;
                main_bus_reqtag = TAG_WR;
            end
            XFER_RWAIT: begin
                bus_busy = 1'b1;
            end
            XFER_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign main_bus_respack = w_respack;

endmodule

// File: tb/tb_line_bus_xfer.sv
// Scoreboard bench for line_bus_xfer: a default 512/64 instance and a 256/128
// instance, with accepted request beats checked against queued expectations.
module tb_line_bus_xfer;

    logic         clk = 1'b0;
    logic         rst_n;
    int           n_vec  = 0;
    int           n_miss = 0;

    logic         enable, write, grant, reqack, respcyc;
    logic [63:0]  addr, resp;
    logic [511:0] wdata, rdata;
    logic [12:0]  resptag, reqtag;
    logic         ready, abtr_reqcyc, bus_busy, reqcyc, respack;
    logic [63:0]  req;

    logic         d2_enable, d2_write, d2_grant, d2_reqack, d2_respcyc;
    logic [63:0]  d2_addr;
    logic [127:0] d2_resp, d2_req;
    logic [255:0] d2_wdata, d2_rdata;
    logic [12:0]  d2_resptag, d2_reqtag;
    logic         d2_ready, d2_abtr_reqcyc, d2_bus_busy, d2_reqcyc, d2_respack;

    logic [76:0]  q1[$];
    logic [140:0] q2[$];

    always #5 clk = ~clk;

    line_bus_xfer u_dut (
        .clk(clk), .reset(rst_n), .enable(enable), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .abtr_reqcyc(abtr_reqcyc),
        .abtr_grant(grant), .bus_busy(bus_busy), .main_bus_reqcyc(reqcyc),
        .main_bus_reqack(reqack), .main_bus_req(req), .main_bus_reqtag(reqtag),
        .main_bus_respcyc(respcyc), .main_bus_resp(resp), .main_bus_resptag(resptag),
        .main_bus_respack(respack)
    );

    line_bus_xfer #(.BUS_DATA_WIDTH(128), .LINE_WIDTH(256)) u_dut2 (
        .clk(clk), .reset(rst_n), .enable(d2_enable), .write(d2_write), .addr(d2_addr),
        .wdata(d2_wdata), .rdata(d2_rdata), .ready(d2_ready), .abtr_reqcyc(d2_abtr_reqcyc),
        .abtr_grant(d2_grant), .bus_busy(d2_bus_busy), .main_bus_reqcyc(d2_reqcyc),
        .main_bus_reqack(d2_reqack), .main_bus_req(d2_req), .main_bus_reqtag(d2_reqtag),
        .main_bus_respcyc(d2_respcyc), .main_bus_resp(d2_resp), .main_bus_resptag(d2_resptag),
        .main_bus_respack(d2_respack)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for the default instance: every accepted request beat pops one expectation.
    always @(negedge clk) begin
        if (rst_n && reqcyc && reqack) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL bus1_extra_beat: got %0h/%0h expected no beat", req, reqtag);
            end else begin
                chk("bus1_beat", {req, reqtag}, q1.pop_front());
            end
        end
    end

    // Monitor for the 256/128 instance.
    always @(negedge clk) begin
        if (rst_n && d2_reqcyc && d2_reqack) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL bus2_extra_beat: got %0h/%0h expected no beat", d2_req, d2_reqtag);
            end else begin
                chk("bus2_beat", {d2_req, d2_reqtag}, q2.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mkline(input logic [63:0] base, input logic [63:0] inc);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + inc * 64'(i);
        return l;
    endfunction

    task automatic push_wb(input logic [63:0] a, input logic [511:0] d, input int nbeats);
        q1.push_back({a & ~64'h3f, 13'h1100});
        for (int i = 0; i < nbeats; i++) q1.push_back({d[i*64 +: 64], 13'h1100});
    endtask

    task automatic start1(input logic wr, input logic [63:0] a, input logic [511:0] d);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        step();
        enable = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        for (int k = 0; k < 40 && !ready; k++) step();
        chk(nm, ready, 1'b1);
    endtask

    initial begin
        logic [511:0] d;
        logic [255:0] d2;
        #100000;
        d = '0;
        d2 = '0;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [255:0] d2;
        rst_n = 1'b0;
        enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        grant = 1'b1; reqack = 1'b1; respcyc = 1'b0; resp = '0; resptag = '0;
        d2_enable = 1'b0; d2_write = 1'b0; d2_addr = '0; d2_wdata = '0;
        d2_grant = 1'b1; d2_reqack = 1'b1; d2_respcyc = 1'b0; d2_resp = '0; d2_resptag = '0;
        #1;
        chk("reset_outputs", {ready, abtr_reqcyc, bus_busy, reqcyc, req, reqtag, respack}, '0);
        chk("reset_rdata", rdata, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ready", ready, 1'b0);

        // Writeback, zero wait states: ready lands 3+8 cycles after the start cycle.
        d = mkline(64'h11, 64'h11);
        push_wb(64'h1234_5678_9ABC_DEF7, d, 8);
        start1(1'b1, 64'h1234_5678_9ABC_DEF7, d);
        repeat (9) step();
        chk("wb_ready_early", ready, 1'b0);
        step();
        chk("wb_ready_latency", ready, 1'b1);
        chk("wb_sb_drain", q1.size(), 0);
        chk("wb_rdata_kept", rdata, '0);

        // Writeback with a 3-cycle reqack stall on beat 4.
        d = mkline(64'h1000_0000_0000_0000, 64'h1);
        push_wb(64'h0000_0000_0000_1040, d, 8);
        start1(1'b1, 64'h0000_0000_0000_1040, d);
        chk("restart_ready_drop", ready, 1'b0);
        for (int k = 0; k < 20 && !(reqcyc && req == d[4*64 +: 64]); k++) step();
        reqack = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall_req", req, d[4*64 +: 64]);
            chk("stall_reqcyc", reqcyc, 1'b1);
            if (s < 2) step();
        end
        reqack = 1'b1;
        wait_ready("stall_ready");
        chk("stall_sb_drain", q1.size(), 0);

        // Fill with a foreign-tagged response inserted before beat 4.
        q1.push_back({64'h0000_0000_8000_0040, 13'h0100});
        start1(1'b0, 64'h0000_0000_8000_0055, '0);
        for (int k = 0; k < 20 && !(bus_busy && !reqcyc); k++) step();
        chk("fill_in_rwait", {bus_busy, reqcyc}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                respcyc = 1'b1; resp = 64'hDEAD; resptag = 13'h1100;
                #1;
                chk("fill_wrongtag_respack", respack, 1'b0);
                step();
            end
            respcyc = 1'b1; resp = 64'hA0 + 64'(i); resptag = 13'h0100;
            #1;
            chk("fill_respack", respack, 1'b1);
            step();
        end
        respcyc = 1'b0;
        chk("fill_ready", ready, 1'b1);
        chk("fill_rdata", rdata, mkline(64'hA0, 64'h1));
        chk("fill_sb_drain", q1.size(), 0);

        // Grant withheld for 5 cycles.
        grant = 1'b0;
        d = mkline(64'h5555_0000_0000_0000, 64'h1);
        push_wb(64'hFFFF_0000_0000_0000, d, 8);
        start1(1'b1, 64'hFFFF_0000_0000_0000, d);
        for (int c = 0; c < 5; c++) begin
            chk("arb_wait", {abtr_reqcyc, bus_busy, reqcyc}, 3'b100);
            if (c < 4) step();
        end
        grant = 1'b1;
        step();
        chk("arb_to_addr", {abtr_reqcyc, bus_busy, reqcyc}, 3'b011);
        chk("arb_addr_beat", req, 64'hFFFF_0000_0000_0000);
        wait_ready("arb_ready");
        chk("arb_sb_drain", q1.size(), 0);

        // Reset while beat 3 is on the bus: beats 0..2 were accepted, nothing after.
        d = mkline(64'h3000, 64'h1);
        push_wb(64'h0000_0000_0000_0040, d, 3);
        start1(1'b1, 64'h0000_0000_0000_0040, d);
        for (int k = 0; k < 20 && !(reqcyc && req == d[3*64 +: 64]); k++) step();
        chk("rst_found_beat3", req, d[3*64 +: 64]);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {ready, abtr_reqcyc, bus_busy, reqcyc, req, reqtag, respack}, '0);
        chk("rst_rdata", rdata, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_idle", {ready, abtr_reqcyc, bus_busy, reqcyc}, 4'b0000);
        chk("rst_sb_drain", q1.size(), 0);
        d = mkline(64'h7700, 64'h10);
        push_wb(64'h0000_0000_0000_2000, d, 8);
        start1(1'b1, 64'h0000_0000_0000_2000, d);
        wait_ready("post_rst_ready");
        chk("post_rst_sb_drain", q1.size(), 0);

        // 256-bit line over a 128-bit bus: address beat plus two data beats.
        d2 = {128'hCAFE_0000_1111_2222_3333_4444_5555_6666, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        q2.push_back({128'h0000_0000_0000_0000_1234_5678_9ABC_DEE0, 13'h1100});
        q2.push_back({d2[127:0], 13'h1100});
        q2.push_back({d2[255:128], 13'h1100});
        d2_enable = 1'b1; d2_write = 1'b1; d2_addr = 64'h1234_5678_9ABC_DEFF; d2_wdata = d2;
        step();
        d2_enable = 1'b0;
        repeat (3) step();
        chk("p2_ready_early", d2_ready, 1'b0);
        step();
        chk("p2_ready_latency", d2_ready, 1'b1);
        chk("p2_sb_drain", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
